alu_addsub_pipe: RTL
====================

// Module: alu_addsub_pipe
// PURPOSE
//  Two-stage pipelined add/subtract unit around carry_select_adder (32-bit, ports a,b,cin,sum,cout).
//  Stage 1 registers the operands and the opcode, then conditions b and cin for the adder.
//  Stage 2 registers the sum and the N/Z/C/V flags.
//  A carry-flag register chains ADC/SBC operations for multi-word arithmetic.
//  Sits between the ALU operand decode and the writeback/status-register logic.
// PARAMETERS
//  WIDTH  32  datapath width; fixed at 32 to match carry_select_adder (any other value is illegal)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      stage 1 can accept; transfer when in_valid & in_ready
//  in_a       in   32     operand A
//  in_b       in   32     operand B
//  in_op      in   2      00 ADD, 01 SUB, 10 ADC, 11 SBC
//  clr_c      in   1      clear the carry-flag register (chain start)
//  out_valid  out  1      result held in stage 2
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  out_sum    out  32     registered sum
//  out_flags  out  4      {N,Z,C,V} of out_sum
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - s1_valid, out_valid, c_flag <= 0; out_sum, out_flags, and the stage-1 regs <= 0.
//   - In-flight ops are discarded. in_ready=1 in the first cycle after reset.
//  Pipeline control:
//   - s2_adv = !out_valid | out_ready.
//   - s1_adv = s1_valid & s2_adv.
//   - in_ready = !s1_valid | s2_adv (combinational; no dependency on in_valid).
//   - Accept: stage 1 loads in_a, in_b, in_op and sets s1_valid.
//   - s1_adv without a new accept clears s1_valid.
//   - Stalled stages hold their contents bit-exact.
//  Operand conditioning (stage 1 -> adder, combinational):
//   - ADD: b=B,  cin=0
//   - SUB: b=~B, cin=1
//   - ADC: b=B,  cin=c_flag
//   - SBC: b=~B, cin=c_flag   (C=1 means no borrow)
//  Stage 2 load on s1_adv:
//   - out_sum <= sum, out_valid <= 1.
//   - N = sum[31]; Z = (sum==0); C = adder cout.
//   - V = (a[31]==b_eff[31]) & (sum[31]!=a[31]), where b_eff is the conditioned b.
//   - If s2_adv and not s1_adv, out_valid <= 0.
//  Latency: 2 cycles from accept edge to out_valid, absent stalls. Throughput: 1 op/cycle.
//  c_flag:
//   - On s1_adv, c_flag <= cout.
//   - c_flag always reflects the previously completed op, so back-to-back ADC needs no bubble.
//   - clr_c=1 forces c_flag <= 0 that edge.
//   - clr_c coincident with s1_adv: the op uses the old c_flag, then c_flag <= 0 (clear wins).
//  Boundaries:
//   - Wrap-around is modulo 2^32; carry is reported only through C.
//   - in_op is sampled only on accept.
//   - Simultaneous out handshake and s1_adv: new result replaces old with out_valid held at 1.
// TESTING
//  1 ADD 7FFFFFFF+00000001 -> sum 80000000, flags N1 Z0 C0 V1; out_valid 2 cycles after accept
//  2 SUB 00000010-00000010 -> sum 00000000, flags N0 Z1 C1 V0; SUB 0-1 -> FFFFFFFF, N1 C0
//  3 clr_c, ADD FFFFFFFF+00000001, then ADC FFFFFFFF+00000000 back-to-back
//    -> 00000000 C1, then 00000000 C1 (64-bit carry chain)
//  4 clr_c, SBC 00000005-00000003 -> 00000001 C1; next SBC 5-3 -> 00000002 C1
//  5 out_ready=0 while issuing ops A,B,C
//    -> A and B accepted, in_ready=0 at C
//    -> after out_ready=1: results A,B,C in order, none lost or duplicated
//  6 rst asserted with both stages full -> next cycle out_valid=0, in_ready=1, c_flag=0;
//    a following ADC 1+1 -> 00000002

Source files
------------

// File: rtl/alu_addsub_pipe_if.sv
// Operand/result handshake bundle for alu_addsub_pipe.
// The producer/consumer side uses the master modport; the ALU uses the slave modport.
interface alu_addsub_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             clr_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_op, clr_c, out_ready,
    input  in_ready, out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, clr_c, out_ready,
    output in_ready, out_valid, out_sum, out_flags
  );
endinterface

// File: rtl/alu_addsub_pipe.sv
// Two-stage pipelined add/subtract unit with a chained carry flag for multi-word ADC/SBC.
// Stage 1 holds operands/opcode and feeds a carry-select adder; stage 2 holds sum and {N,Z,C,V}.
module alu_addsub_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  alu_addsub_pipe_if.slave bus
);
  localparam int unsigned BLK  = 4;
  localparam int unsigned NBLK = WIDTH / BLK;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic             c_flag_q, c_flag_d;

  logic             s1_adv, s2_adv, accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  assign s2_adv       = !out_valid_q | bus.out_ready;
  assign s1_adv       = s1_valid_q & s2_adv;
  assign bus.in_ready = !s1_valid_q | s2_adv;
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_flags = out_flags_q;

  // SBC uses the stored carry directly: C=1 means no borrow into this word.
  always_comb begin
    b_eff = s1_b_q;
    cin   = 1'b0;
    case (s1_op_q)
      OP_ADD: begin b_eff = s1_b_q;  cin = 1'b0;     end
      OP_SUB: begin b_eff = ~s1_b_q; cin = 1'b1;     end
      OP_ADC: begin b_eff = s1_b_q;  cin = c_flag_q; end
      OP_SBC: begin b_eff = ~s1_b_q; cin = c_flag_q; end
      default: ;
    endcase
  end

  // Each block precomputes its sum for carry-in 0 and 1; the carry chain only selects.
  logic [NBLK-1:0][BLK:0] blk_c0, blk_c1;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    assign blk_c0[g] = {1'b0, s1_a_q[g*BLK +: BLK]} + {1'b0, b_eff[g*BLK +: BLK]};
    assign blk_c1[g] = {1'b0, s1_a_q[g*BLK +: BLK]} + {1'b0, b_eff[g*BLK +: BLK]}
                       + {{BLK{1'b0}}, 1'b1};
  end

  logic         carry;
  logic [BLK:0] pick;

  always_comb begin
    sum   = '0;
    carry = cin;
    pick  = '0;
    for (int unsigned i = 0; i < NBLK; i++) begin
      pick              = carry ? blk_c1[i] : blk_c0[i];
      sum[i*BLK +: BLK] = pick[BLK-1:0];
      carry             = pick[BLK];
    end
    cout = carry;
  end

  assign ovf = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != s1_a_q[WIDTH-1]);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_flags_d = out_flags_q;
    c_flag_d    = c_flag_q;

    if (accept) begin
      s1_a_d     = bus.in_a;
      s1_b_d     = bus.in_b;
      s1_op_d    = op_e'(bus.in_op);
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_sum_d   = sum;
      out_flags_d = {sum[WIDTH-1], (sum == '0), cout, ovf};
      out_valid_d = 1'b1;
    end else if (s2_adv) begin
      out_valid_d = 1'b0;
    end

    // A clear coincident with an advancing op lets that op see the old carry first.
    if (bus.clr_c) begin
      c_flag_d = 1'b0;
    end else if (s1_adv) begin
      c_flag_d = cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_flags_q <= '0;
      c_flag_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_flags_q <= out_flags_d;
      c_flag_q    <= c_flag_d;
    end
  end
endmodule
